// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC interrupt gateway.
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_CLAIMED
  } gw_state_e;

  localparam int PLIC_ID_W = 8;

  // Edge counter width; a zero-depth queue still gets one (constant-zero) bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// Single-source PLIC gateway: IDLE/PENDING/CLAIMED handshake FSM with an
// optional saturating queue of edges that arrive while the source is busy.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int MAX_PENDING_COUNT = 0
) (
  input  logic h_clk,
  input  logic h_rstn,
  input  logic src,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic ip,
  output logic busy
);

  localparam int CNT_W = cnt_width(MAX_PENDING_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

  gw_state_e        state;
  logic             src_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;
  logic             edge_det;
  logic             cnt_nz;
  logic             trigger;

  always_comb begin
    edge_det = src & ~src_q;
    cnt_nz   = (cnt != '0);
    trigger  = edge_mode ? (edge_det | cnt_nz) : src;
  end

  // mode_q freezes the trigger mode while busy so a mid-flight change only
  // takes effect once the source is back in IDLE.
  always_ff @(posedge h_clk) begin
    if (!h_rstn) begin
      state  <= GW_IDLE;
      ip     <= 1'b0;
      busy   <= 1'b0;
      src_q  <= 1'b0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else begin
      src_q <= src;
      case (state)
        GW_IDLE: begin
          mode_q <= edge_mode;
          if (!edge_mode) begin
            cnt <= '0;
          end
          if (trigger) begin
            state <= GW_PENDING;
            ip    <= 1'b1;
            busy  <= 1'b1;
            if (edge_mode && cnt_nz && !edge_det) begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        GW_PENDING: begin
          if (claim_hit) begin
            state <= GW_CLAIMED;
            ip    <= 1'b0;
          end
        end
        GW_CLAIMED: begin
          if (complete_hit) begin
            state <= GW_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= GW_IDLE;
          ip    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      if ((state != GW_IDLE) && mode_q && edge_det && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway stage: one gateway cell per source plus claim/complete ID decode.
// Optional macro PLIC_GW_SYNC_EN inserts a 2-flop synchroniser on every src line.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int SOURCES           = 1,
  parameter int MAX_PENDING_COUNT = 0,
  parameter int ID_W              = PLIC_ID_W
) (
  input  logic               h_clk,
  input  logic               h_rstn,
  input  logic [SOURCES-1:0] src,
  input  logic [SOURCES-1:0] edge_mode,
  output logic [SOURCES-1:0] ip,
  input  logic               claim_valid,
  input  logic [ID_W-1:0]    claim_id,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [SOURCES-1:0] busy
);

  logic [SOURCES-1:0] src_s;
  logic [SOURCES-1:0] claim_hit;
  logic [SOURCES-1:0] complete_hit;

`ifdef PLIC_GW_SYNC_EN
  logic [SOURCES-1:0] sync_1;
  logic [SOURCES-1:0] sync_2;

  always_ff @(posedge h_clk) begin
    if (!h_rstn) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= src;
      sync_2 <= sync_1;
    end
  end

  assign src_s = sync_2;
`else
  assign src_s = src;
`endif

  // IDs are 1-based, so ID 0 and anything above SOURCES never match a cell.
  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    assign claim_hit[i]    = claim_valid    && (claim_id    == ID_W'(i + 1));
    assign complete_hit[i] = complete_valid && (complete_id == ID_W'(i + 1));

    plic_gateway_cell #(
      .MAX_PENDING_COUNT(MAX_PENDING_COUNT)
    ) u_cell (
      .h_clk       (h_clk),
      .h_rstn      (h_rstn),
      .src         (src_s[i]),
      .edge_mode   (edge_mode[i]),
      .claim_hit   (claim_hit[i]),
      .complete_hit(complete_hit[i]),
      .ip          (ip[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: vector table on a MAX_PENDING_COUNT=2
// instance plus hand-written timing sequences and a MAX_PENDING_COUNT=0 instance.
module tb_plic_gateway;

  localparam int SRC = 4;
`ifdef PLIC_GW_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  logic           h_rstn;
  logic [SRC-1:0] a_src, a_edge_mode, a_ip, a_busy;
  logic           a_cv, a_kv;
  logic [7:0]     a_cid, a_kid;
  logic [SRC-1:0] b_src, b_edge_mode, b_ip, b_busy;
  logic           b_cv, b_kv;
  logic [7:0]     b_cid, b_kid;

  plic_gateway #(.SOURCES(SRC), .MAX_PENDING_COUNT(2), .ID_W(8)) u_dut_a (
    .h_clk(h_clk), .h_rstn(h_rstn), .src(a_src), .edge_mode(a_edge_mode),
    .ip(a_ip), .claim_valid(a_cv), .claim_id(a_cid),
    .complete_valid(a_kv), .complete_id(a_kid), .busy(a_busy)
  );

  plic_gateway #(.SOURCES(SRC), .MAX_PENDING_COUNT(0), .ID_W(8)) u_dut_b (
    .h_clk(h_clk), .h_rstn(h_rstn), .src(b_src), .edge_mode(b_edge_mode),
    .ip(b_ip), .claim_valid(b_cv), .claim_id(b_cid),
    .complete_valid(b_kv), .complete_id(b_kid), .busy(b_busy)
  );

  typedef struct {
    logic [SRC-1:0] src;
    logic           cv;
    logic [7:0]     cid;
    logic           kv;
    logic [7:0]     kid;
    logic [SRC-1:0] ip;
    logic [SRC-1:0] busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add_vec(input logic [SRC-1:0] s, input logic cv, input logic [7:0] cid,
                                  input logic kv, input logic [7:0] kid,
                                  input logic [SRC-1:0] eip, input logic [SRC-1:0] ebusy);
    vec_t v;
    v.src = s; v.cv = cv; v.cid = cid; v.kv = kv; v.kid = kid; v.ip = eip; v.busy = ebusy;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge h_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [SRC-1:0] act_ip, input logic [SRC-1:0] exp_ip,
                              input logic [SRC-1:0] act_busy, input logic [SRC-1:0] exp_busy);
    n_vec++;
    if (act_ip !== exp_ip || act_busy !== exp_busy) begin
      n_bad++;
      $display("[TB] FAIL %s: got ip=%b busy=%b, expected ip=%b busy=%b",
               name, act_ip, act_busy, exp_ip, exp_busy);
    end
  endtask

  // Strobes last one cycle; the rest of the slot lets src settle through any synchroniser.
  task automatic apply_stimulus(input vec_t v);
    a_src = v.src; a_cv = v.cv; a_cid = v.cid; a_kv = v.kv; a_kid = v.kid;
    step();
    a_cv = 1'b0; a_kv = 1'b0; a_cid = '0; a_kid = '0;
    repeat (1 + SYNC_EXTRA) step();
  endtask

  task automatic settle();
    repeat (2 + SYNC_EXTRA) step();
  endtask

  initial begin
    int lat;
    h_rstn = 1'b0;
    a_src = '0; a_edge_mode = 4'b0001; a_cv = 0; a_cid = '0; a_kv = 0; a_kid = '0;
    b_src = '0; b_edge_mode = 4'b0001; b_cv = 0; b_cid = '0; b_kv = 0; b_kid = '0;

    // Source 0 is edge-triggered, sources 1..3 are level-triggered.
    add_vec(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
    add_vec(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0100);
    add_vec(4'b0000, 0, 0, 0, 0, 4'b0100, 4'b0100);
    add_vec(4'b0000, 1, 0, 0, 0, 4'b0100, 4'b0100);
    add_vec(4'b0000, 1, 5, 0, 0, 4'b0100, 4'b0100);
    add_vec(4'b0000, 1, 3, 0, 0, 4'b0000, 4'b0100);
    add_vec(4'b0000, 0, 0, 1, 1, 4'b0000, 4'b0100);
    add_vec(4'b0000, 0, 0, 1, 3, 4'b0000, 4'b0000);
    add_vec(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001);
    add_vec(4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0001);
    add_vec(4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0001);
    for (int p = 0; p < 3; p++) begin
      add_vec(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001);
      add_vec(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0001);
    end
    add_vec(4'b0000, 0, 0, 1, 1, 4'b0001, 4'b0001);
    add_vec(4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0001);
    add_vec(4'b0000, 0, 0, 1, 1, 4'b0001, 4'b0001);
    add_vec(4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0001);
    add_vec(4'b0000, 0, 0, 1, 1, 4'b0000, 4'b0000);
    add_vec(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
    add_vec(4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010);
    add_vec(4'b0010, 0, 0, 1, 2, 4'b0010, 4'b0010);
    add_vec(4'b0010, 1, 2, 0, 0, 4'b0000, 4'b0010);
    add_vec(4'b0010, 1, 2, 0, 0, 4'b0000, 4'b0010);
    add_vec(4'b0011, 0, 0, 0, 0, 4'b0001, 4'b0011);
    add_vec(4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0011);

    repeat (3) step();
    check_output("reset_a", a_ip, 4'b0000, a_busy, 4'b0000);
    check_output("reset_b", b_ip, 4'b0000, b_busy, 4'b0000);
    h_rstn = 1'b1;
    step();

    for (int k = 0; k < vecs.size(); k++) begin
      apply_stimulus(vecs[k]);
      check_output($sformatf("vec%0d", k), a_ip, vecs[k].ip, a_busy, vecs[k].busy);
    end

    // Source 0 PENDING, source 1 CLAIMED: both handshakes land on one edge.
    a_cv = 1; a_cid = 8'd1; a_kv = 1; a_kid = 8'd2;
    step();
    a_cv = 0; a_kv = 0; a_cid = '0; a_kid = '0;
    check_output("dual_handshake", a_ip, 4'b0000, a_busy, 4'b0001);
    a_kv = 1; a_kid = 8'd1;
    step();
    a_kv = 0; a_kid = '0;
    settle();
    check_output("dual_cleanup", a_ip, 4'b0000, a_busy, 4'b0000);

    // Level source latency, then re-pend two edges after completion.
    a_src = 4'b0100;
    lat = 0;
    while (a_ip[2] !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    n_vec++;
    if (lat != 1 + SYNC_EXTRA) begin
      n_bad++;
      $display("[TB] FAIL src_to_ip_latency: got %0d cycles, expected %0d", lat, 1 + SYNC_EXTRA);
    end
    a_cv = 1; a_cid = 8'd3;
    step();
    a_cv = 0; a_cid = '0;
    check_output("lvl_claim", a_ip, 4'b0000, a_busy, 4'b0100);
    a_kv = 1; a_kid = 8'd3;
    step();
    a_kv = 0; a_kid = '0;
    check_output("lvl_complete_edge1", a_ip, 4'b0000, a_busy, 4'b0000);
    step();
    check_output("lvl_complete_edge2", a_ip, 4'b0100, a_busy, 4'b0100);
    a_cv = 1; a_cid = 8'd3;
    step();
    a_cv = 0; a_cid = '0; a_src = 4'b0000;
    a_kv = 1; a_kid = 8'd3;
    step();
    a_kv = 0; a_kid = '0;
    settle();
    check_output("lvl_idle", a_ip, 4'b0000, a_busy, 4'b0000);

    // Reset while CLAIMED with one queued edge.
    a_src = 4'b0001; settle();
    a_cv = 1; a_cid = 8'd1;
    step();
    a_cv = 0; a_cid = '0;
    a_src = 4'b0000; settle();
    a_src = 4'b0001; settle();
    a_src = 4'b0000; settle();
    check_output("pre_reset_claimed", a_ip, 4'b0000, a_busy, 4'b0001);
    h_rstn = 1'b0;
    step();
    check_output("mid_reset", a_ip, 4'b0000, a_busy, 4'b0000);
    h_rstn = 1'b1;
    repeat (4 + SYNC_EXTRA) step();
    check_output("post_reset_cnt_cleared", a_ip, 4'b0000, a_busy, 4'b0000);

    // Zero-depth queue: an edge while PENDING is dropped.
    b_src = 4'b0001; settle();
    check_output("b_pend", b_ip, 4'b0001, b_busy, 4'b0001);
    b_src = 4'b0000; settle();
    b_src = 4'b0001; settle();
    b_src = 4'b0000; settle();
    check_output("b_edge_while_pending", b_ip, 4'b0001, b_busy, 4'b0001);
    b_cv = 1; b_cid = 8'd1;
    step();
    b_cv = 0; b_cid = '0;
    check_output("b_claim", b_ip, 4'b0000, b_busy, 4'b0001);
    b_kv = 1; b_kid = 8'd1;
    step();
    b_kv = 0; b_kid = '0;
    repeat (4 + SYNC_EXTRA) step();
    check_output("b_no_repend", b_ip, 4'b0000, b_busy, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
